// File: rtl/iob_cache_be_responder_if.sv
// Native cache back-end memory bus: request channel from the cache,
// ready/read-response channel back from the memory side.
// Signal suffixes are named from the responder's point of view.
interface iob_cache_be_responder_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic                  be_valid_i;
    logic [ADDR_W-1:0]     be_addr_i;
    logic [DATA_W-1:0]     be_wdata_i;
    logic [DATA_W/8-1:0]   be_wstrb_i;
    logic                  be_ready_o;
    logic [DATA_W-1:0]     be_rdata_o;
    logic                  be_rvalid_o;

    // Cache side: issues requests, consumes ready and read data.
    modport master (
        output be_valid_i, be_addr_i, be_wdata_i, be_wstrb_i,
        input  be_ready_o, be_rdata_o, be_rvalid_o
    );

    // Memory responder side.
    modport slave (
        input  be_valid_i, be_addr_i, be_wdata_i, be_wstrb_i,
        output be_ready_o, be_rdata_o, be_rvalid_o
    );
endinterface

// File: rtl/iob_cache_be_responder.sv
// Back-end memory responder for the cache: byte-strobed writes, fixed-latency
// pipelined reads and an optional periodic ready stall. Memory words alias
// modulo the depth; upper address bits and byte offsets are ignored.
module iob_cache_be_responder #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 32,
    parameter int MEM_ADDR_W   = 10,
    parameter int READ_LAT     = 2,
    parameter int STALL_PERIOD = 0
) (
    input  logic                     clk_i,
    input  logic                     cke_i,
    input  logic                     rst_i,
    iob_cache_be_responder_if.slave  be_if
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = (NB > 1) ? $clog2(NB) : 0;
    localparam int DEPTH = 1 << MEM_ADDR_W;
    localparam int SC_W  = (STALL_PERIOD >= 2) ? $clog2(STALL_PERIOD) : 1;

    // Parameter sanity: reject configurations the pipeline/stall logic cannot honour.
    generate
        if (READ_LAT < 1 || READ_LAT > 8) begin : g_bad_read_lat
            $error("iob_cache_be_responder: READ_LAT must be within 1..8");
        end
        if (STALL_PERIOD == 1 || STALL_PERIOD < 0) begin : g_bad_stall_period
            $error("iob_cache_be_responder: STALL_PERIOD must be 0 or >= 2");
        end
        if (ADDR_W < MEM_ADDR_W + OFF_W) begin : g_bad_addr_w
            $error("iob_cache_be_responder: ADDR_W too narrow for MEM_ADDR_W");
        end
        if ((DATA_W % 8) != 0) begin : g_bad_data_w
            $error("iob_cache_be_responder: DATA_W must be a multiple of 8");
        end
    endgenerate

    logic [SC_W-1:0]       stall_cnt_q;
    logic [SC_W-1:0]       stall_cnt_d;
    logic                  stall;
    logic                  ready;
    logic                  accept;
    logic                  rd_accept;
    logic                  is_write;
    logic [MEM_ADDR_W-1:0] word_idx;

    logic [DATA_W-1:0]     mem_q [DEPTH];

    logic [READ_LAT-1:0]   valid_q;
    logic [READ_LAT-1:0]   valid_d;
    logic [DATA_W-1:0]     data_q [READ_LAT];
    logic [DATA_W-1:0]     data_d [READ_LAT];

    // Free-running stall phase: ready drops on the last count of every period.
    generate
        if (STALL_PERIOD >= 2) begin : g_stall
            localparam logic [SC_W-1:0] LAST = SC_W'(STALL_PERIOD - 1);
            assign stall       = (stall_cnt_q == LAST);
            assign stall_cnt_d = stall ? '0 : stall_cnt_q + SC_W'(1);
        end else begin : g_no_stall
            assign stall       = 1'b0;
            assign stall_cnt_d = '0;
        end
    endgenerate

    // Stall counter advances every enabled cycle, independent of traffic.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (cke_i) begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ready     = ~rst_i & cke_i & ~stall;
    assign accept    = be_if.be_valid_i & ready;
    assign is_write  = |be_if.be_wstrb_i;
    assign rd_accept = accept & ~is_write;
    assign word_idx  = be_if.be_addr_i[MEM_ADDR_W+OFF_W-1:OFF_W];

    // Byte-enabled write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (accept && is_write) begin
            for (int b = 0; b < NB; b++) begin
                if (be_if.be_wstrb_i[b]) begin
                    mem_q[word_idx][b*8 +: 8] <= be_if.be_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Read pipeline next state: stage 0 captures the addressed word, later
    // stages shift only when a valid word moves in so the tail holds its data.
    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        valid_d[0] = rd_accept;
        if (rd_accept) begin
            data_d[0] = mem_q[word_idx];
        end
        for (int i = 1; i < READ_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            if (valid_q[i-1]) begin
                data_d[i] = data_q[i-1];
            end
        end
    end

    // Read pipeline registers; reset drops all in-flight reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else if (cke_i) begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign be_if.be_ready_o  = ready;
    assign be_if.be_rvalid_o = valid_q[READ_LAT-1];
    assign be_if.be_rdata_o  = data_q[READ_LAT-1];

    // Address bits outside the word index (and the counter when stalls are off)
    // are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{be_if.be_addr_i, stall_cnt_q};

endmodule

// File: tb/tb_iob_cache_be_responder.sv
// Directed bench for the back-end responder. Three instances cover the
// configurations exercised: (LAT=2, no stall), (LAT=3, no stall), (LAT=2, stall every 4).
module tb_iob_cache_be_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        cke;
    logic        valid;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          sel;
    int          cyc = 0;

    int n_vec = 0;
    int n_err = 0;

    logic        ready_m;
    logic        rvalid_m;
    logic [31:0] rdata_m;

    logic [31:0] rsp_q[$];
    int          rsp_cyc[$];

    always #5 clk = ~clk;

    iob_cache_be_responder_if #(.ADDR_W(24), .DATA_W(32)) if0 ();
    iob_cache_be_responder_if #(.ADDR_W(24), .DATA_W(32)) if1 ();
    iob_cache_be_responder_if #(.ADDR_W(24), .DATA_W(32)) if2 ();

    assign if0.be_valid_i = valid && (sel == 0);
    assign if0.be_addr_i  = addr;
    assign if0.be_wdata_i = wdata;
    assign if0.be_wstrb_i = wstrb;
    assign if1.be_valid_i = valid && (sel == 1);
    assign if1.be_addr_i  = addr;
    assign if1.be_wdata_i = wdata;
    assign if1.be_wstrb_i = wstrb;
    assign if2.be_valid_i = valid && (sel == 2);
    assign if2.be_addr_i  = addr;
    assign if2.be_wdata_i = wdata;
    assign if2.be_wstrb_i = wstrb;

    iob_cache_be_responder #(.ADDR_W(24), .DATA_W(32), .MEM_ADDR_W(10),
                             .READ_LAT(2), .STALL_PERIOD(0)) dut0 (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .be_if(if0.slave));
    iob_cache_be_responder #(.ADDR_W(24), .DATA_W(32), .MEM_ADDR_W(10),
                             .READ_LAT(3), .STALL_PERIOD(0)) dut1 (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .be_if(if1.slave));
    iob_cache_be_responder #(.ADDR_W(24), .DATA_W(32), .MEM_ADDR_W(10),
                             .READ_LAT(2), .STALL_PERIOD(4)) dut2 (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .be_if(if2.slave));

    // Observe the selected instance.
    always_comb begin
        case (sel)
            1: begin
                ready_m = if1.be_ready_o; rvalid_m = if1.be_rvalid_o; rdata_m = if1.be_rdata_o;
            end
            2: begin
                ready_m = if2.be_ready_o; rvalid_m = if2.be_rvalid_o; rdata_m = if2.be_rdata_o;
            end
            default: begin
                ready_m = if0.be_ready_o; rvalid_m = if0.be_rvalid_o; rdata_m = if0.be_rdata_o;
            end
        endcase
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rvalid_m) begin
            rsp_q.push_back(rdata_m);
            rsp_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("vec %0d %s: got %h ok", n_vec, tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rsp();
        rsp_q.delete();
        rsp_cyc.delete();
    endtask

    // Present one request and hold it until accepted; reports stall cycles waited.
    task automatic do_req(input logic [23:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int waits);
        addr  = a;
        wdata = d;
        wstrb = s;
        valid = 1'b1;
        waits = 0;
        #1;
        while (!ready_m && waits < 20) begin
            step();
            waits++;
        end
        if (!ready_m) begin
            check("req_accept_timeout", 32'(ready_m), 32'd1);
            valid = 1'b0;
            return;
        end
        step();
        valid = 1'b0;
    endtask

    // Single isolated read: checks latency from accept edge and returned data.
    task automatic do_read(input logic [23:0] a, input logic [31:0] exp,
                           input int lat, input string tag);
        int w;
        int acc;
        clear_rsp();
        do_req(a, 32'h0, 4'h0, w);
        acc = cyc;
        for (int n = 0; n < 12 && rsp_q.size() == 0; n++) begin
            @(negedge clk);
            #1;
        end
        if (rsp_q.size() == 0) begin
            check({tag, "_timeout"}, 32'(rsp_q.size()), 32'd1);
        end else begin
            check({tag, "_lat"}, 32'(rsp_cyc[0] - acc + 1), 32'(lat));
            check({tag, "_data"}, rsp_q[0], exp);
        end
    endtask

    initial begin
        int          w;
        int          acc;
        logic [7:0]  pat;

        rst = 1'b1; cke = 1'b1; valid = 1'b0;
        addr = '0; wdata = '0; wstrb = '0; sel = 0;
        repeat (3) step();
        check("rst_ready", 32'(ready_m), 32'd0);
        check("rst_rvalid", 32'(rvalid_m), 32'd0);
        check("rst_rdata", rdata_m, 32'h0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(ready_m), 32'd1);

        // Write then read, LAT=2; a write produces no response.
        clear_rsp();
        do_req(24'h000010, 32'hDEADBEEF, 4'hF, w);
        repeat (4) step();
        check("t1_wr_no_rvalid", 32'(rsp_q.size()), 32'd0);
        do_read(24'h000010, 32'hDEADBEEF, 2, "t1_rd");
        step();
        check("t1_pulse_end", 32'(rvalid_m), 32'd0);
        check("t1_rdata_hold", rdata_m, 32'hDEADBEEF);

        // Byte strobes, with read immediately after the write.
        do_req(24'h000020, 32'h11223344, 4'hF, w);
        do_req(24'h000020, 32'hAABBCCDD, 4'h5, w);
        do_read(24'h000020, 32'h11BB33DD, 2, "t2_strb");

        // Aliasing modulo the 1024-word depth and ignored byte offset.
        do_req(24'h001000, 32'h5A5A5A5A, 4'hF, w);
        do_read(24'h000000, 32'h5A5A5A5A, 2, "t5_alias");
        do_read(24'h000002, 32'h5A5A5A5A, 2, "t5_offset");

        // Clock enable low: ready drops and rvalid holds.
        clear_rsp();
        do_req(24'h000010, 32'h0, 4'h0, w);
        for (int n = 0; n < 12 && rsp_q.size() == 0; n++) begin
            @(negedge clk);
            #1;
        end
        cke = 1'b0;
        #1;
        check("cke_ready_low", 32'(ready_m), 32'd0);
        repeat (2) step();
        check("cke_rvalid_hold", 32'(rvalid_m), 32'd1);
        cke = 1'b1;
        step();
        check("cke_resume_pulse_end", 32'(rvalid_m), 32'd0);

        // Back-to-back reads, LAT=3.
        sel = 1;
        for (int i = 0; i < 4; i++) do_req(24'(i * 4), 32'hA0 + 32'(i), 4'hF, w);
        clear_rsp();
        do_req(24'h0, 32'h0, 4'h0, w);
        acc = cyc;
        for (int i = 1; i < 4; i++) do_req(24'(i * 4), 32'h0, 4'h0, w);
        repeat (10) step();
        check("t3_count", 32'(rsp_q.size()), 32'd4);
        if (rsp_q.size() == 4) begin
            check("t3_lat", 32'(rsp_cyc[0] - acc + 1), 32'd3);
            check("t3_b2b_span", 32'(rsp_cyc[3] - rsp_cyc[0]), 32'd3);
            for (int i = 0; i < 4; i++)
                check($sformatf("t3_rd%0d", i), rsp_q[i], 32'hA0 + 32'(i));
        end
        clear_rsp();
        do_req(24'h000000, 32'h0, 4'h0, w);
        do_req(24'h000004, 32'h0, 4'h0, w);
        do_req(24'h000040, 32'h00000077, 4'hF, w);
        do_req(24'h000008, 32'h0, 4'h0, w);
        do_req(24'h00000C, 32'h0, 4'h0, w);
        repeat (10) step();
        check("t3i_count", 32'(rsp_q.size()), 32'd4);
        if (rsp_q.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("t3i_rd%0d", i), rsp_q[i], 32'hA0 + 32'(i));
        end

        // Reset mid-flight drops both reads; memory survives.
        clear_rsp();
        do_req(24'h000000, 32'h0, 4'h0, w);
        do_req(24'h000004, 32'h0, 4'h0, w);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (8) step();
        check("t6_no_rvalid", 32'(rsp_q.size()), 32'd0);
        check("t6_rdata_rst", rdata_m, 32'h0);
        do_read(24'h000000, 32'hA0, 3, "t6_rd0");
        do_read(24'h000040, 32'h77, 3, "t6_rd40");

        // Stall every 4th cycle, phase fixed by a fresh reset.
        sel = 2;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            pat[i] = ready_m;
            step();
        end
        check("t4_ready_pattern", 32'(pat), 32'h77);
        for (int i = 0; i < 6; i++) begin
            do_req(24'(i * 4), 32'hB0 + 32'(i), 4'hF, w);
            check($sformatf("t4_wr%0d_waits", i), 32'(w), (i == 3) ? 32'd1 : 32'd0);
        end
        clear_rsp();
        for (int i = 0; i < 6; i++) do_req(24'(i * 4), 32'h0, 4'h0, w);
        repeat (10) step();
        check("t4_rd_count", 32'(rsp_q.size()), 32'd6);
        if (rsp_q.size() == 6) begin
            for (int i = 0; i < 6; i++)
                check($sformatf("t4_rd%0d", i), rsp_q[i], 32'hB0 + 32'(i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
